// File: rtl/sync_ack_requester.sv
// Event-to-handshake requester: queues ev_in pulses and issues them one at a time
// to a toggle synchronizer through a vld_out pulse / rdy_in acknowledge cycle.
module sync_ack_requester #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_a,
    input  logic             a_reset_in,
    input  logic             ev_in,
    output logic             vld_out,
    input  logic             rdy_in,
    input  logic             clr_in,
    output logic [CNT_W-1:0] pending_out,
    output logic             busy_out,
    output logic             ovf_out,
    output logic             timeout_out
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  PEND_MAX = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_LOW = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;
    logic              to_set;
    logic              ovf_set;
    logic              wait_enter;

    // Expires in the TIMEOUT-th cycle spent in the current wait phase.
    assign wait_expired = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT));
    assign ovf_set      = ev_in && !vld_out && (pending_out == PEND_MAX);
    assign wait_enter   = ((state_next == WAIT_LOW) && (state != WAIT_LOW)) ||
                          ((state_next == WAIT_ACK) && (state != WAIT_ACK));
    assign busy_out     = (state != IDLE);

    always_comb begin
        state_next = state;
        to_set     = 1'b0;
        case (state)
            IDLE: begin
                if ((pending_out != '0) && rdy_in) state_next = ISSUE;
            end
            ISSUE: state_next = WAIT_LOW;
            WAIT_LOW: begin
                if (!rdy_in) begin
                    state_next = WAIT_ACK;
                end else if (wait_expired) begin
                    state_next = IDLE;
                    to_set     = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (rdy_in) begin
                    state_next = IDLE;
                end else if (wait_expired) begin
                    state_next = IDLE;
                    to_set     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_a) begin
        if (a_reset_in) begin
            state       <= IDLE;
            vld_out     <= 1'b0;
            wait_cnt    <= '0;
            pending_out <= '0;
            ovf_out     <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            state   <= state_next;
            vld_out <= (state_next == ISSUE);

            if (wait_enter || (state_next == IDLE)) begin
                wait_cnt <= '0;
            end else if (((state == WAIT_LOW) || (state == WAIT_ACK)) && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // A timed-out issue already left the counter in its vld_out cycle.
            if (ev_in && !vld_out) begin
                if (!ovf_set) pending_out <= pending_out + 1'b1;
            end else if (!ev_in && vld_out) begin
                pending_out <= pending_out - 1'b1;
            end

            ovf_out     <= ovf_set || (ovf_out && !clr_in);
            timeout_out <= to_set || (timeout_out && !clr_in);
        end
    end

endmodule

// File: tb/tb_sync_ack_requester.sv
// Scoreboard bench for sync_ack_requester: driver feeds a transaction-level
// reference model into queues, a monitor compares DUT outputs after each edge.
module tb_sync_ack_requester;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 8;
    localparam int PMAX    = (1 << CNT_W) - 1;

    logic             clk_a = 1'b0;
    logic             a_reset_in = 1'b1;
    logic             ev_in = 1'b0;
    logic             rdy_in = 1'b1;
    logic             clr_in = 1'b0;
    logic             vld_out;
    logic [CNT_W-1:0] pending_out;
    logic             busy_out;
    logic             ovf_out;
    logic             timeout_out;

    always #5 clk_a = ~clk_a;

    sync_ack_requester #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_a       (clk_a),
        .a_reset_in  (a_reset_in),
        .ev_in       (ev_in),
        .vld_out     (vld_out),
        .rdy_in      (rdy_in),
        .clr_in      (clr_in),
        .pending_out (pending_out),
        .busy_out    (busy_out),
        .ovf_out     (ovf_out),
        .timeout_out (timeout_out)
    );

    typedef struct packed {
        logic [CNT_W-1:0] pend;
        logic             vld;
        logic             busy;
        logic             ovf;
        logic             to;
    } obs_t;

    obs_t exp_q[$];
    int   issue_q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    int   cyc = 0;

    // Reference model: queued event count, sticky flags, and handshake progress
    // (0 free, 1 issuing, 2 awaiting ready drop, 3 awaiting ready rise).
    int m_pend = 0;
    bit m_ovf = 0, m_to = 0, m_vld = 0;
    int m_phase = 0;
    int m_cyc = 0;

    // Synchronizer model: ready low over [lo_at, hi_at) step indices.
    int lo_at = -1, hi_at = -1;
    bit stuck = 0;
    bit force_low = 0;

    task automatic model_step(input bit rst, input bit ev, input bit rdy, input bit clr);
        int nph, ncyc;
        bit to_set, ovf_set, ended;
        obs_t e;
        if (rst) begin
            m_pend = 0; m_ovf = 0; m_to = 0; m_vld = 0; m_phase = 0; m_cyc = 0;
        end else begin
            nph = m_phase; ncyc = m_cyc + 1; to_set = 0;
            case (m_phase)
                0: if (m_pend > 0 && rdy) nph = 1;
                1: begin nph = 2; ncyc = 1; end
                default: begin
                    ended = (m_phase == 2) ? !rdy : rdy;
                    if (ended) begin
                        nph = (m_phase == 2) ? 3 : 0;
                        ncyc = 1;
                    end else if (m_cyc == TIMEOUT) begin
                        nph = 0;
                        to_set = 1;
                    end
                end
            endcase
            ovf_set = ev && !m_vld && (m_pend == PMAX);
            if (ev && !m_vld && !ovf_set) m_pend = m_pend + 1;
            else if (!ev && m_vld) m_pend = m_pend - 1;
            m_ovf = ovf_set || (m_ovf && !clr);
            m_to  = to_set || (m_to && !clr);
            m_phase = nph;
            m_cyc = ncyc;
            m_vld = (nph == 1);
        end
        e.pend = CNT_W'(m_pend);
        e.vld  = m_vld;
        e.busy = (m_phase != 0);
        e.ovf  = m_ovf;
        e.to   = m_to;
        exp_q.push_back(e);
        if (m_vld) issue_q.push_back(cyc + 1);
    endtask

    task automatic step(input bit rst, input bit ev, input bit clr);
        bit r;
        r = force_low ? 1'b0 : !(cyc >= lo_at && cyc < hi_at);
        a_reset_in = rst;
        ev_in      = ev;
        clr_in     = clr;
        rdy_in     = r;
        model_step(rst, ev, r, clr);
        if (m_vld) begin
            lo_at = cyc + 1 + int'($urandom_range(0, 2));
            hi_at = lo_at + (stuck ? TIMEOUT + 4 : int'($urandom_range(1, 4)));
        end
        @(negedge clk_a);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    always @(posedge clk_a) begin
        obs_t e, got;
        edge_n++;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {pending_out, vld_out, busy_out, ovf_out, timeout_out};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL status edge %0d: got pend=%0d vld=%b busy=%b ovf=%b to=%b, want pend=%0d vld=%b busy=%b ovf=%b to=%b",
                         edge_n, got.pend, got.vld, got.busy, got.ovf, got.to,
                         e.pend, e.vld, e.busy, e.ovf, e.to);
            end
        end
        if (vld_out === 1'b1) begin
            while (issue_q.size() > 0 && issue_q[0] < edge_n) void'(issue_q.pop_front());
            total++;
            if (issue_q.size() > 0 && issue_q[0] == edge_n) begin
                void'(issue_q.pop_front());
            end else begin
                bad++;
                $display("FAIL issue edge %0d: got unexpected vld_out pulse, want next issue at edge %0d",
                         edge_n, (issue_q.size() > 0) ? issue_q[0] : -1);
            end
        end
    end

    initial begin
        // Reset, with an event during reset that must be discarded.
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        idle(3);

        // Single event.
        step(0, 1, 0);
        idle(10);

        // Burst of five.
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        idle(40);

        // Saturation with ready held low, then clear and drain.
        force_low = 1;
        for (int i = 0; i < PMAX + 3; i++) step(0, 1, 0);
        idle(2);
        step(0, 0, 1);
        idle(2);
        force_low = 0;
        idle(60);

        // Timeout with a second event queued behind it.
        stuck = 1;
        step(0, 1, 0);
        step(0, 1, 0);
        idle(25);
        stuck = 0;
        idle(40);
        step(0, 0, 1);

        // Reset while waiting for the ack with two events pending.
        stuck = 1;
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            if (m_phase == 3 && m_pend == 2) break;
            step(0, 0, 0);
        end
        step(1, 0, 0);
        stuck = 0;
        idle(20);
        step(0, 1, 0);
        idle(20);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            stuck = ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 19) == 0));
        end
        stuck = 0;
        idle(60);

        @(posedge clk_a);
        #2;
        total++;
        if (exp_q.size() != 0 || issue_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d status and %0d issues outstanding, want 0 and 0",
                     exp_q.size(), issue_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
